// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master main-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_BCW = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD,
        ARB_WR
    } arb_state_t;

    typedef logic owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Tie-break between two requesters. MEM_ARB_FIXED_PRIO_EN selects fixed m0-first
// priority; otherwise round-robin against the last granted master.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last,
    output owner_t grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb grant = req1 & ~req0;
`else
    // On a tie the master that did not win last time goes first.
    always_comb grant = (req0 & req1) ? ~last : req1;
`endif

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master main-memory arbiter; grant is held for a whole read or write burst.
// Build option MEM_ARB_FIXED_PRIO_EN (in mem_arb_grant) switches to fixed priority.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int unsigned BCW = MEM_ARB_BCW
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic [31:0]     m0_addr,
    input  logic [31:0]     m0_din,
    input  logic [3:0]      m0_be,
    input  logic [BCW-1:0]  m0_burstcount,
    input  logic            m0_rd,
    input  logic            m0_we,
    output logic            m0_busy,
    output logic [31:0]     m0_dout,
    output logic            m0_dout_ready,

    input  logic [31:0]     m1_addr,
    input  logic [31:0]     m1_din,
    input  logic [3:0]      m1_be,
    input  logic [BCW-1:0]  m1_burstcount,
    input  logic            m1_rd,
    input  logic            m1_we,
    output logic            m1_busy,
    output logic [31:0]     m1_dout,
    output logic            m1_dout_ready,

    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_din,
    output logic [3:0]      mem_be,
    output logic [BCW-1:0]  mem_burstcount,
    output logic            mem_rd,
    output logic            mem_we,
    input  logic            mem_busy,
    input  logic [31:0]     mem_dout,
    input  logic            mem_dout_ready
);

    localparam int unsigned CW = BCW + 1;

    arb_state_t     state;
    owner_t         owner;
    owner_t         last;
    owner_t         grant;
    owner_t         sel;
    logic [CW-1:0]  remaining;
    logic [CW-1:0]  cnt;
    logic           req0, req1;
    logic           s_rd, s_we;
    logic           accept;
    logic           rd_beat;

    assign req0 = m0_rd | m0_we;
    assign req1 = m1_rd | m1_we;

    mem_arb_grant u_grant (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .grant (grant)
    );

    // Zero-latency grant while idle; the owner keeps the port during a burst.
    always_comb begin
        sel            = (state == ARB_IDLE) ? grant : owner;
        mem_addr       = sel ? m1_addr       : m0_addr;
        mem_din        = sel ? m1_din        : m0_din;
        mem_be         = sel ? m1_be         : m0_be;
        mem_burstcount = sel ? m1_burstcount : m0_burstcount;
        s_rd           = sel ? m1_rd         : m0_rd;
        s_we           = sel ? m1_we         : m0_we;
    end

    always_comb begin
        mem_rd = reset_n & (state == ARB_IDLE) & s_rd;
        // A simultaneous rd+we is treated as a read; the write is not forwarded.
        mem_we = reset_n & (((state == ARB_IDLE) & s_we & ~s_rd) |
                            ((state == ARB_WR) & s_we));
        accept = (mem_rd | mem_we) & ~mem_busy;
        cnt    = (mem_burstcount == '0) ? CW'(1) : {1'b0, mem_burstcount};
    end

    always_comb begin
        m0_busy = 1'b1;
        m1_busy = 1'b1;
        if (reset_n && state != ARB_RD) begin
            if (sel) m1_busy = mem_busy;
            else     m0_busy = mem_busy;
        end
    end

    // Beats outside a read burst (stray or after a reset) are dropped here.
    assign rd_beat       = reset_n & (state == ARB_RD) & mem_dout_ready;
    assign m0_dout_ready = rd_beat & ~owner;
    assign m1_dout_ready = rd_beat & owner;
    assign m0_dout       = mem_dout;
    assign m1_dout       = mem_dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            remaining <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        owner <= sel;
                        last  <= sel;
                        if (mem_rd) begin
                            state     <= ARB_RD;
                            remaining <= cnt;
                        end else if (cnt == CW'(1)) begin
                            remaining <= '0;
                        end else begin
                            state     <= ARB_WR;
                            remaining <= cnt - CW'(1);
                        end
                    end
                end
                ARB_RD: begin
                    if (mem_dout_ready) begin
                        remaining <= remaining - CW'(1);
                        if (remaining <= CW'(1)) state <= ARB_IDLE;
                    end
                end
                ARB_WR: begin
                    if (mem_we && !mem_busy) begin
                        remaining <= remaining - CW'(1);
                        if (remaining <= CW'(1)) state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    a_m0_rd_we: assert property (@(posedge clk) disable iff (!reset_n) !(m0_rd && m0_we));
    a_m1_rd_we: assert property (@(posedge clk) disable iff (!reset_n) !(m1_rd && m1_we));

endmodule

// File: tb/tb_mem_arbiter2.sv
// Randomized and directed bench for mem_arbiter2 against a transaction-level model.
module tb_mem_arbiter2;

    localparam int BCW = 8;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [31:0]     m_addr [2];
    logic [31:0]     m_din  [2];
    logic [3:0]      m_be   [2];
    logic [BCW-1:0]  m_bc   [2];
    logic            m_rd   [2];
    logic            m_we   [2];
    logic            d_busy [2];
    logic [31:0]     d_dout [2];
    logic            d_dr   [2];
    logic [31:0]     mem_addr, mem_din, mem_dout;
    logic [3:0]      mem_be;
    logic [BCW-1:0]  mem_burstcount;
    logic            mem_rd, mem_we, mem_busy, mem_dout_ready;

    int total = 0;
    int bad   = 0;

    // Model: one outstanding transaction holding the port, plus tie history.
    bit t_act = 0, t_read = 0;
    int t_own = 0, t_left = 0, rr_last = 1, be_pend = 0;
    bit acc_rd [2];
    bit acc_we [2];
    int n_dr [2];
    int n_we = 0, n_busy0 = 0;

    mem_arbiter2 #(.BCW(BCW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_addr(m_addr[0]), .m0_din(m_din[0]), .m0_be(m_be[0]), .m0_burstcount(m_bc[0]),
        .m0_rd(m_rd[0]), .m0_we(m_we[0]), .m0_busy(d_busy[0]), .m0_dout(d_dout[0]),
        .m0_dout_ready(d_dr[0]),
        .m1_addr(m_addr[1]), .m1_din(m_din[1]), .m1_be(m_be[1]), .m1_burstcount(m_bc[1]),
        .m1_rd(m_rd[1]), .m1_we(m_we[1]), .m1_busy(d_busy[1]), .m1_dout(d_dout[1]),
        .m1_dout_ready(d_dr[1]),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
        .mem_burstcount(mem_burstcount), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_busy(mem_busy), .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle reference check, sampled mid-cycle while inputs are stable.
    int         c_g, c_n;
    logic [1:0] c_rq, c_busy, c_dr, c_chkb;
    logic       c_rd, c_we;
    always @(negedge clk) begin
        acc_rd = '{0, 0};
        acc_we = '{0, 0};
        c_rq   = {m_rd[1] | m_we[1], m_rd[0] | m_we[0]};
        c_busy = 2'b11;
        c_dr   = 2'b00;
        c_rd   = 1'b0;
        c_we   = 1'b0;
        c_chkb = 2'b11;
        c_g    = 0;
        if (!reset_n) begin
            t_act   = 0;
            rr_last = 1;
        end else if (!t_act) begin
            if (c_rq == 2'b11) c_g = FIXED ? 0 : 1 - rr_last;
            else               c_g = c_rq[1] ? 1 : 0;
            c_rd         = m_rd[c_g];
            c_we         = m_we[c_g] && !m_rd[c_g];
            c_busy[c_g]  = mem_busy;
            c_chkb       = c_rq;
            if ((c_rd || c_we) && !mem_busy) begin
                rr_last = c_g;
                c_n = (m_bc[c_g] == 0) ? 1 : int'(m_bc[c_g]);
                if (c_rd) begin
                    t_act = 1; t_read = 1; t_own = c_g; t_left = c_n;
                    be_pend = c_n;
                    acc_rd[c_g] = 1;
                end else begin
                    acc_we[c_g] = 1;
                    if (c_n > 1) begin
                        t_act = 1; t_read = 0; t_own = c_g; t_left = c_n - 1;
                    end
                end
            end
        end else if (t_read) begin
            c_g = t_own;
            c_dr[c_g] = mem_dout_ready;
            if (mem_dout_ready) begin
                t_left--;
                if (t_left == 0) t_act = 0;
            end
        end else begin
            c_g = t_own;
            c_we = m_we[c_g];
            c_busy[c_g] = mem_busy;
            if (m_we[c_g] && !mem_busy) begin
                acc_we[c_g] = 1;
                t_left--;
                if (t_left == 0) t_act = 0;
            end
        end
        chk("mem_rd", 32'(mem_rd), 32'(c_rd));
        chk("mem_we", 32'(mem_we), 32'(c_we));
        for (int x = 0; x < 2; x++) begin
            if (c_chkb[x]) chk($sformatf("m%0d_busy", x), 32'(d_busy[x]), 32'(c_busy[x]));
            chk($sformatf("m%0d_dout_ready", x), 32'(d_dr[x]), 32'(c_dr[x]));
            chk($sformatf("m%0d_dout", x), d_dout[x], mem_dout);
            if (d_dr[x]) n_dr[x]++;
        end
        if (c_rd || c_we) begin
            chk("mem_addr", mem_addr, m_addr[c_g]);
            chk("mem_burstcount", 32'(mem_burstcount), 32'(m_bc[c_g]));
            if (c_we) begin
                chk("mem_din", mem_din, m_din[c_g]);
                chk("mem_be", 32'(mem_be), 32'(m_be[c_g]));
            end
        end
        if (mem_we) n_we++;
        if (d_busy[0]) n_busy0++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        mem_dout = d;
        mem_dout_ready = 1'b1;
        tick();
        mem_dout_ready = 1'b0;
    endtask

    int ph [2];
    int wleft [2];
    int w;

    initial begin
        for (int x = 0; x < 2; x++) begin
            m_addr[x] = '0; m_din[x] = '0; m_be[x] = '0; m_bc[x] = '0;
            m_rd[x] = 1'b0; m_we[x] = 1'b0; n_dr[x] = 0; ph[x] = 0; wleft[x] = 0;
        end
        mem_busy = 1'b0; mem_dout = '0; mem_dout_ready = 1'b0;

        // Reset holds everything quiet even with a request present.
        m_rd[0] = 1'b1;
        tick();
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_m0_busy", 32'(d_busy[0]), 1);
        chk("rst_m1_busy", 32'(d_busy[1]), 1);
        m_rd[0] = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // T1: tie after reset goes to m0, then m1 after m0's four beats.
        m_addr[0] = 32'h100; m_bc[0] = 4; m_rd[0] = 1'b1;
        m_addr[1] = 32'h200; m_bc[1] = 4; m_rd[1] = 1'b1;
        n_dr = '{0, 0};
        #1;
        chk("t1_first_addr", mem_addr, 32'h100);
        chk("t1_m1_busy", 32'(d_busy[1]), 1);
        chk("t1_m0_busy", 32'(d_busy[0]), 0);
        tick();
        m_rd[0] = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'h1000 + 32'(i));
        chk("t1_m0_beats", 32'(n_dr[0]), 4);
        chk("t1_m1_grant_rd", 32'(mem_rd), 1);
        chk("t1_m1_grant_addr", mem_addr, 32'h200);
        tick();
        m_rd[1] = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'h2000 + 32'(i));
        chk("t1_m1_beats", 32'(n_dr[1]), 4);
        chk("t1_m0_extra", 32'(n_dr[0]), 4);

        // T2: solo m0 read, then a tie goes to m1 (m0 under fixed priority).
        m_addr[0] = 32'h300; m_bc[0] = 1; m_rd[0] = 1'b1;
        tick();
        m_rd[0] = 1'b0;
        beat(32'h3);
        m_rd[0] = 1'b1;
        m_addr[1] = 32'h400; m_bc[1] = 1; m_rd[1] = 1'b1;
        #1;
        chk("t2_tie_addr", mem_addr, FIXED ? 32'h300 : 32'h400);
        w = FIXED ? 0 : 1;
        tick();
        m_rd[w] = 1'b0;
        beat(32'h4);
        tick();
        m_rd[1 - w] = 1'b0;
        beat(32'h5);

        // T3: m1 write of three beats with a gap; m0 read waits for the burst.
        n_we = 0;
        m_addr[1] = 32'h500; m_bc[1] = 3; m_din[1] = 32'hD1; m_be[1] = 4'hF; m_we[1] = 1'b1;
        tick();
        m_we[1] = 1'b0;
        m_addr[0] = 32'h600; m_bc[0] = 1; m_rd[0] = 1'b1;
        #1;
        chk("t3_m0_busy_gap", 32'(d_busy[0]), 1);
        chk("t3_no_rd_gap", 32'(mem_rd), 0);
        tick();
        m_we[1] = 1'b1; m_din[1] = 32'hD2;
        tick();
        m_din[1] = 32'hD3;
        tick();
        m_we[1] = 1'b0;
        #1;
        chk("t3_we_pulses", 32'(n_we), 3);
        chk("t3_m0_rd", 32'(mem_rd), 1);
        chk("t3_m0_addr", mem_addr, 32'h600);
        tick();
        m_rd[0] = 1'b0;
        beat(32'h6);

        // T4: backend stall of five cycles on a burstcount-0 read, then a stray beat.
        m_addr[0] = 32'h700; m_bc[0] = 0; m_rd[0] = 1'b1;
        mem_busy = 1'b1;
        n_busy0 = 0;
        repeat (5) tick();
        mem_busy = 1'b0;
        #1;
        chk("t4_busy_cycles", 32'(n_busy0), 5);
        chk("t4_rd", 32'(mem_rd), 1);
        tick();
        m_rd[0] = 1'b0;
        n_dr = '{0, 0};
        beat(32'h7);
        beat(32'h77);
        chk("t4_single_beat", 32'(n_dr[0]), 1);
        chk("t4_stray_m1", 32'(n_dr[1]), 0);

        // T5: reset after two of eight beats; the remaining six are dropped.
        m_addr[0] = 32'h800; m_bc[0] = 8; m_rd[0] = 1'b1;
        tick();
        m_rd[0] = 1'b0;
        beat(32'h80);
        beat(32'h81);
        reset_n = 1'b0;
        m_rd[1] = 1'b1; m_addr[1] = 32'h900; m_bc[1] = 1;
        #1;
        chk("t5_rst_rd", 32'(mem_rd), 0);
        chk("t5_rst_busy0", 32'(d_busy[0]), 1);
        chk("t5_rst_busy1", 32'(d_busy[1]), 1);
        n_dr = '{0, 0};
        tick();
        reset_n = 1'b1;
        m_rd[1] = 1'b0;
        for (int i = 0; i < 6; i++) beat(32'h82 + 32'(i));
        chk("t5_dropped_m0", 32'(n_dr[0]), 0);
        chk("t5_dropped_m1", 32'(n_dr[1]), 0);
        m_rd[1] = 1'b1;
        #1;
        chk("t5_regrant_rd", 32'(mem_rd), 1);
        chk("t5_regrant_addr", mem_addr, 32'h900);
        tick();
        m_rd[1] = 1'b0;
        beat(32'h90);
        chk("t5_m1_beat", 32'(n_dr[1]), 1);

        // T6: single-beat write with partial byte enables stays idle.
        m_addr[0] = 32'hA00; m_bc[0] = 1; m_be[0] = 4'b0101; m_din[0] = 32'hAABBCCDD;
        m_we[0] = 1'b1;
        #1;
        chk("t6_we", 32'(mem_we), 1);
        chk("t6_be", 32'(mem_be), 32'h5);
        chk("t6_din", mem_din, 32'hAABBCCDD);
        tick();
        m_we[0] = 1'b0;
        m_rd[1] = 1'b1; m_addr[1] = 32'hB00; m_bc[1] = 1;
        #1;
        chk("t6_idle_after", 32'(mem_rd), 1);
        tick();
        m_rd[1] = 1'b0;
        beat(32'hB0);

        // Random traffic from both masters against a randomly stalling backend.
        be_pend = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            for (int x = 0; x < 2; x++) begin
                case (ph[x])
                    0: if ($urandom_range(3) == 0) begin
                        m_addr[x] = $urandom;
                        m_din[x]  = $urandom;
                        m_be[x]   = 4'($urandom);
                        m_bc[x]   = BCW'($urandom_range(5));
                        if ($urandom_range(1) == 0) begin
                            m_rd[x] = 1'b1;
                            ph[x] = 1;
                        end else begin
                            m_we[x] = 1'b1;
                            wleft[x] = (m_bc[x] == 0) ? 1 : int'(m_bc[x]);
                            ph[x] = 3;
                        end
                    end
                    1: if (acc_rd[x]) begin
                        m_rd[x] = 1'b0;
                        ph[x] = 2;
                    end
                    2: if (!(t_act && t_read && t_own == x)) ph[x] = 0;
                    default: begin
                        if (acc_we[x]) begin
                            wleft[x]--;
                            m_din[x] = $urandom;
                            m_be[x]  = 4'($urandom);
                            if (wleft[x] == 0) begin
                                m_we[x] = 1'b0;
                                ph[x] = 0;
                            end else begin
                                m_we[x] = ($urandom_range(2) != 0);
                            end
                        end else if (!m_we[x]) begin
                            m_we[x] = 1'b1;
                        end
                    end
                endcase
            end
            mem_busy = ($urandom_range(3) == 0);
            mem_dout = $urandom;
            mem_dout_ready = 1'b0;
            if (t_act && t_read && be_pend > 0) begin
                if ($urandom_range(2) != 0) begin
                    mem_dout_ready = 1'b1;
                    be_pend--;
                end
            end else if (!(t_act && t_read) && be_pend == 0 && $urandom_range(15) == 0) begin
                mem_dout_ready = 1'b1;
            end
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
